// File: rtl/kpn_sequence_writer_if.sv
// rtl/kpn_sequence_writer_if.sv - FIFO write-side bundle between the sequence writer and its FIFO
// master = writer process, slave = FIFO / observer side.
interface kpn_sequence_writer_if #(
  parameter int WIDTH = 16
);
  logic             enable;
  logic             full;
  logic             wr;
  logic [WIDTH-1:0] output_1;
  logic [15:0]      tokens_written;
  logic             done;

  modport master (
    input  enable,
    input  full,
    output wr,
    output output_1,
    output tokens_written,
    output done
  );

  modport slave (
    output enable,
    output full,
    input  wr,
    input  output_1,
    input  tokens_written,
    input  done
  );
endinterface

// File: rtl/kpn_sequence_writer.sv
// rtl/kpn_sequence_writer.sv - bounded arithmetic-sequence token writer with FIFO backpressure
// Writes START, START+STEP, ... into a FIFO, stalling on full and pausing on enable=0.
module kpn_sequence_writer #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] START = '0,
  parameter logic [WIDTH-1:0] STEP  = WIDTH'(1),
  parameter int unsigned      COUNT = 16,
  parameter int unsigned      GAP   = 0
) (
  input logic                     clk,
  input logic                     rst_n,
  kpn_sequence_writer_if.master   fifo
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam bit         BOUNDED = (COUNT != 0);
  localparam bit         HAS_GAP = (GAP != 0);
  localparam logic [7:0] GAP_M1  = 8'(GAP - 1);

  state_t           state_q;
  logic [WIDTH-1:0] token_q;
  logic [15:0]      count_q;
  logic             done_q;
  logic [7:0]       gap_q;
  logic             wr;
  logic             last;

  // The strobe is combinational so a full flag in the same cycle blocks the write.
  assign wr   = (state_q == S_WRITE) & fifo.enable & ~fifo.full;
  assign last = ((32'(count_q) + 32'd1) == 32'(COUNT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      token_q <= START;
      count_q <= '0;
      done_q  <= 1'b0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fifo.enable) state_q <= S_WRITE;
        end
        S_WRITE: begin
          if (wr) begin
            token_q <= token_q + STEP;
            count_q <= count_q + 16'd1;
            // Reaching COUNT wins over inserting a gap.
            if (BOUNDED && last) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (HAS_GAP) begin
              state_q <= S_GAP;
              gap_q   <= GAP_M1;
            end
          end
        end
        S_GAP: begin
          if (fifo.enable) begin
            if (gap_q == 8'd0) state_q <= S_WRITE;
            else               gap_q   <= gap_q - 8'd1;
          end
        end
        default: begin
          state_q <= S_DONE;
        end
      endcase
    end
  end

  assign fifo.wr             = wr;
  assign fifo.output_1       = token_q;
  assign fifo.tokens_written = count_q;
  assign fifo.done           = done_q;

endmodule

// File: tb/tb_kpn_sequence_writer.sv
// tb/tb_kpn_sequence_writer.sv - randomized check of six writer configurations against a token-count model
module tb_kpn_sequence_writer;

  localparam int N = 6;
  // Per-instance configuration: START, STEP, COUNT, GAP, WIDTH.
  localparam longint unsigned C_START [N] = '{64'd0, 64'd10, 64'hFFFE, 64'd7, 64'd0, 64'd250};
  localparam longint unsigned C_STEP  [N] = '{64'd1, 64'd5,  64'd1,    64'd3, 64'd1, 64'd3};
  localparam int              C_COUNT [N] = '{4, 3, 4, 0, 0, 20};
  localparam int              C_GAP   [N] = '{0, 2, 0, 1, 0, 3};
  localparam int              C_WIDTH [N] = '{16, 16, 16, 16, 16, 8};

  logic clk = 1'b0;
  logic rst_n;
  logic en [N];
  logic fl [N];

  logic        obs_wr   [N];
  logic [31:0] obs_tok  [N];
  logic [31:0] obs_tw   [N];
  logic        obs_done [N];

  int total = 0;
  int bad   = 0;

  int  k         [N];
  bit  started   [N];
  bit  mdone     [N];
  int  idle_left [N];
  bit  chk_on = 1'b0;

  always #5 clk = ~clk;

  kpn_sequence_writer_if #(.WIDTH(16)) if0 ();
  kpn_sequence_writer_if #(.WIDTH(16)) if1 ();
  kpn_sequence_writer_if #(.WIDTH(16)) if2 ();
  kpn_sequence_writer_if #(.WIDTH(16)) if3 ();
  kpn_sequence_writer_if #(.WIDTH(16)) if4 ();
  kpn_sequence_writer_if #(.WIDTH(8))  if5 ();

  kpn_sequence_writer #(.WIDTH(16), .START(16'd0), .STEP(16'd1), .COUNT(4), .GAP(0))
    u0 (.clk(clk), .rst_n(rst_n), .fifo(if0));
  kpn_sequence_writer #(.WIDTH(16), .START(16'd10), .STEP(16'd5), .COUNT(3), .GAP(2))
    u1 (.clk(clk), .rst_n(rst_n), .fifo(if1));
  kpn_sequence_writer #(.WIDTH(16), .START(16'hFFFE), .STEP(16'd1), .COUNT(4), .GAP(0))
    u2 (.clk(clk), .rst_n(rst_n), .fifo(if2));
  kpn_sequence_writer #(.WIDTH(16), .START(16'd7), .STEP(16'd3), .COUNT(0), .GAP(1))
    u3 (.clk(clk), .rst_n(rst_n), .fifo(if3));
  kpn_sequence_writer #(.WIDTH(16), .START(16'd0), .STEP(16'd1), .COUNT(0), .GAP(0))
    u4 (.clk(clk), .rst_n(rst_n), .fifo(if4));
  kpn_sequence_writer #(.WIDTH(8), .START(8'd250), .STEP(8'd3), .COUNT(20), .GAP(3))
    u5 (.clk(clk), .rst_n(rst_n), .fifo(if5));

  assign if0.enable = en[0]; assign if0.full = fl[0];
  assign if1.enable = en[1]; assign if1.full = fl[1];
  assign if2.enable = en[2]; assign if2.full = fl[2];
  assign if3.enable = en[3]; assign if3.full = fl[3];
  assign if4.enable = en[4]; assign if4.full = fl[4];
  assign if5.enable = en[5]; assign if5.full = fl[5];

  assign obs_wr[0] = if0.wr; assign obs_tok[0] = 32'(if0.output_1);
  assign obs_wr[1] = if1.wr; assign obs_tok[1] = 32'(if1.output_1);
  assign obs_wr[2] = if2.wr; assign obs_tok[2] = 32'(if2.output_1);
  assign obs_wr[3] = if3.wr; assign obs_tok[3] = 32'(if3.output_1);
  assign obs_wr[4] = if4.wr; assign obs_tok[4] = 32'(if4.output_1);
  assign obs_wr[5] = if5.wr; assign obs_tok[5] = 32'(if5.output_1);
  assign obs_tw[0] = 32'(if0.tokens_written); assign obs_done[0] = if0.done;
  assign obs_tw[1] = 32'(if1.tokens_written); assign obs_done[1] = if1.done;
  assign obs_tw[2] = 32'(if2.tokens_written); assign obs_done[2] = if2.done;
  assign obs_tw[3] = 32'(if3.tokens_written); assign obs_done[3] = if3.done;
  assign obs_tw[4] = 32'(if4.tokens_written); assign obs_done[4] = if4.done;
  assign obs_tw[5] = 32'(if5.tokens_written); assign obs_done[5] = if5.done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Token k of the sequence is START + k*STEP reduced to the instance width.
  function automatic logic [31:0] exp_token(input int i);
    longint unsigned m;
    m = 64'd1 << C_WIDTH[i];
    return 32'((C_START[i] + longint'(k[i]) * C_STEP[i]) % m);
  endfunction

  function automatic logic exp_wr(input int i);
    return started[i] && !mdone[i] && idle_left[i] == 0 && en[i] && !fl[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      k[i] = 0; started[i] = 1'b0; mdone[i] = 1'b0; idle_left[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      if (!started[i]) begin
        if (en[i]) started[i] = 1'b1;
      end else if (mdone[i]) begin
      end else if (idle_left[i] > 0) begin
        if (en[i]) idle_left[i]--;
      end else if (en[i] && !fl[i]) begin
        k[i]++;
        if (C_COUNT[i] != 0 && k[i] == C_COUNT[i]) mdone[i] = 1'b1;
        else idle_left[i] = C_GAP[i];
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (chk_on) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("wr%0d", i),   32'(obs_wr[i]),   32'(exp_wr(i)));
        check($sformatf("tok%0d", i),  obs_tok[i],       exp_token(i));
        check($sformatf("tw%0d", i),   obs_tw[i],        32'(k[i] % 65536));
        check($sformatf("done%0d", i), 32'(obs_done[i]), 32'(mdone[i]));
      end
    end
    if (!rst_n) model_reset();
    else        model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < N; i++) begin
      en[i] = ($urandom % 8) != 0;
      fl[i] = ($urandom % 4) == 0;
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin en[i] = 1'b0; fl[i] = 1'b0; end
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Phase A: instance 0 runs unobstructed, the rest see random enable/full.
    for (int c = 0; c < 400; c++) begin
      randomize_inputs();
      en[0] = 1'b1; fl[0] = 1'b0;
      cycle();
    end
    check("i0_done", 32'(obs_done[0]), 32'd1);
    check("i0_tw",   obs_tw[0],        32'd4);
    check("i0_tok",  obs_tok[0],       32'd4);
    check("i1_tok",  obs_tok[1],       32'd25);
    check("i2_tok",  obs_tok[2],       32'h0002);
    check("i5_tok",  obs_tok[5],       32'd54);
    check("i5_done", 32'(obs_done[5]), 32'd1);

    // One-cycle reset in the middle of instance 3's unbounded run, FIFO full.
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin en[i] = 1'b1; fl[i] = 1'b1; end
    cycle();
    rst_n = 1'b1;
    check("rst_tok3",  obs_tok[3],       32'd7);
    check("rst_tw3",   obs_tw[3],        32'd0);
    check("rst_wr3",   32'(obs_wr[3]),   32'd0);
    check("rst_done0", 32'(obs_done[0]), 32'd0);

    // Phase B: instance 4 writes 70000 tokens back-to-back.
    guard = 0;
    while (k[4] < 70000 && guard < 71000) begin
      randomize_inputs();
      en[4] = 1'b1; fl[4] = 1'b0;
      cycle();
      guard++;
    end
    check("i4_budget", 32'(k[4]), 32'd70000);
    en[4] = 1'b0;
    cycle();
    check("i4_tw_wrap", obs_tw[4],        32'd4464);
    check("i4_done",    32'(obs_done[4]), 32'd0);
    check("i4_tok",     obs_tok[4],       32'(70000 % 65536));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kpn_sequence_writer.md
# kpn_sequence_writer

Producer process for the KPN datapath: generates an arithmetic sequence of WIDTH-bit tokens and writes them into a downstream FIFO with blocking-write semantics, stalling on the FIFO full flag. It is the writer end of the FIFO interface that the adder and LCD processes read from (rd/output_1). It replaces free-running token sources with a bounded, backpressure-aware one.

## Interface
- WIDTH, 16, token width in bits
- START, 0, first token value
- STEP, 1, increment between consecutive tokens, modulo 2^WIDTH
- COUNT, 16, number of tokens to write; 0 = unbounded
- GAP, 0, idle cycles inserted after each accepted write (0..255)
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- enable  in  1  process run/pause; 0 holds all state and forces wr=0
- full  in  1  downstream FIFO full flag
- wr  out  1  FIFO write strobe; a token is written on every rising edge where wr=1
- output_1  out  WIDTH  token presented to FIFO entry_1
- tokens_written  out  16  count of accepted writes, wraps modulo 2^16
- done  out  1  high once COUNT tokens are written (never asserts when COUNT=0)

## Operation
- States: IDLE, WRITE, GAP, DONE.
- Reset (rst_n=0 at an edge, from any state, mid-sequence included): state=IDLE, output_1=START, tokens_written=0, done=0, gap counter=0. wr reads 0 while in IDLE.
- wr is combinational: wr = (state==WRITE) & enable & ~full. No registered strobe; never asserted while full=1.
- IDLE: enable=1 at edge -> WRITE; otherwise stay.
- WRITE, edge with wr=1 (write accepted):
  - output_1 <= output_1 + STEP (truncated to WIDTH, wraps).
  - tokens_written <= tokens_written + 1.
  - if COUNT!=0 and tokens_written+1==COUNT -> DONE (takes priority over GAP).
  - else if GAP!=0 -> GAP, gap counter <= GAP-1.
  - else stay WRITE (back-to-back writes, one per cycle).
- WRITE, edge with wr=0 (full=1 or enable=0): hold everything; output_1 stays stable until accepted.
- GAP: wr=0; if enable=1, counter decrements each edge; at counter==0 edge -> WRITE. enable=0 freezes counter.
- DONE: done=1, wr=0, output_1 holds START+COUNT*STEP (mod 2^WIDTH); stays until reset. enable and full ignored.
- full and enable may toggle any cycle; only their value at the edge matters for acceptance.

## Timing
- First wr: earliest the cycle after the edge at which enable=1 is sampled in IDLE (1-cycle start latency).
- Throughput: 1 token/cycle with GAP=0 and full=0; 1 token per GAP+1 cycles otherwise.
- Token k (0-based) = START + k*STEP mod 2^WIDTH, presented on output_1 in the same cycle wr is high for it.
- done rises the cycle after the edge accepting the COUNT-th token; wr is 0 from that cycle on.
- full asserting in a WRITE cycle blocks that cycle's write combinationally; no token is lost or duplicated.
- tokens_written and done are registered, updated at the accepting edge.

## Test plan
- Reset then enable=1, full=0, START=0, STEP=1, COUNT=4, GAP=0 -> wr high 4 consecutive cycles with output_1 = 0,1,2,3; done=1 next cycle, tokens_written=4, wr=0 thereafter.
- Backpressure: COUNT=3, full=1 for cycles 2-5 of writing -> output_1 held at token 1 with wr=0 while full, then 1,2 resume; exactly 3 tokens written, no duplicates.
- GAP=2, COUNT=3, STEP=5, START=10 -> writes 10, 15, 20 each separated by exactly 2 idle cycles; done after third.
- Wrap: WIDTH=16, START=16'hFFFE, STEP=1, COUNT=4 -> tokens FFFE, FFFF, 0000, 0001.
- enable dropped mid-sequence for 3 cycles (including during GAP) -> wr=0, counters/output_1 frozen; sequence resumes unchanged on re-enable.
- rst_n=0 for one cycle mid-sequence with full=1 -> next cycle wr=0, output_1=START, tokens_written=0, done=0, state IDLE; COUNT=0 run of 70000 writes never asserts done and tokens_written wraps to 4464.
